mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter and boot sequencer.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_LDR = 1;
  localparam int unsigned NPORTS   = 2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker producing a one-hot grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last,
  input  logic [NPORTS-1:0] en,
  output logic [NPORTS-1:0] gnt
);

  logic [NPORTS-1:0] elig;

  // On a tie the port not granted last wins.
  always_comb begin
    elig = req & en;
    gnt  = elig;
    if (elig == 2'b11) begin
      gnt           = '0;
      gnt[PORT_CPU] = last;
      gnt[PORT_LDR] = ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between the CPU (port 0) and the loader (port 1),
// holding the CPU off during boot and arbitrating round-robin afterwards.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              boot_done,
  output logic              cpu_hold,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              rd_pend;
  logic              rd_own;
  logic [NPORTS-1:0] en;
  logic [NPORTS-1:0] gnt;

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // DRAIN issues no grants, so the only read it can see is the one returning
  // this cycle; nothing is outstanding afterwards.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (boot_done) state_nxt = DRAIN;
      DRAIN:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    en       = '0;
    cpu_hold = 1'b1;
    case (state)
      BOOT:    en[PORT_LDR] = 1'b1;
      RUN: begin
        en       = '1;
        cpu_hold = 1'b0;
      end
      default: en = '0;
    endcase
    if (reset) begin
      en       = '0;
      cpu_hold = 1'b1;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req  ({req1, req0}),
    .last (last),
    .en   (en),
    .gnt  (gnt)
  );

  assign gnt0 = gnt[PORT_CPU];
  assign gnt1 = gnt[PORT_LDR];

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[PORT_LDR]) begin
      mem_re    = ~we1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt[PORT_CPU]) begin
      mem_re    = ~we0;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last    <= 1'b0;
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
    end else begin
      rd_pend <= mem_re;
      if (|gnt) begin
        last   <= gnt[PORT_LDR];
        rd_own <= gnt[PORT_LDR];
      end
    end
  end

  // Read return is steered to the owning port; the other port sees zero.
  assign rvalid0 = ~reset & rd_pend & ~rd_own;
  assign rvalid1 = ~reset & rd_pend & rd_own;
  assign rdata0  = rvalid0 ? mem_rdata : DATA_W'(0);
  assign rdata1  = rvalid1 ? mem_rdata : DATA_W'(0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, boot_done;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, cpu_hold, mem_re, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
  end

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .boot_done(boot_done), .cpu_hold(cpu_hold),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; boot_done = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'h1;
    req0 = 1;
    @(negedge clk); @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %b exp 1", cpu_hold); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", {gnt0, gnt1}); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {mem_re, mem_we}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {rvalid0, rvalid1}); end
    next_cycle();
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_boot_write();
    req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'hDEADBEEF;
    req0 = 1; we0 = 0; addr0 = 32'h40;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL boot_gnt1 got %b exp 1", gnt1); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL boot_gnt0 got %b exp 0", gnt0); end
    checks++; if ({mem_we, mem_re} !== 2'b10) begin errors++; $display("FAIL boot_strobes got %b exp 10", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL boot_addr got %h exp 00000010", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL boot_wdata got %h exp deadbeef", mem_wdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL boot_hold got %b exp 1", cpu_hold); end
    next_cycle();
    addr1 = 32'h20; wdata1 = 32'h11112222;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL boot_w20 got %b%b exp 10", gnt1, gnt0); end
    next_cycle();
    addr1 = 32'h24; wdata1 = 32'h33334444;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h24 || mem_we !== 1'b1) begin errors++; $display("FAIL boot_w24 got %h/%b exp 00000024/1", mem_addr, mem_we); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_boot_read_done();
    req1 = 1; we1 = 0; addr1 = 32'h10; boot_done = 1;
    req0 = 1; we0 = 0; addr0 = 32'h40;
    @(negedge clk);
    checks++; if ({gnt1, mem_re, gnt0} !== 3'b110) begin errors++; $display("FAIL bd_grant got %b exp 110", {gnt1, mem_re, gnt0}); end
    next_cycle();
    req1 = 0; boot_done = 0;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL drain_rvalid1 got %b exp 1", rvalid1); end
    checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_rdata1 got %h exp deadbeef", rdata1); end
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL drain_port0 got %b/%h exp 0/0", rvalid0, rdata0); end
    checks++; if (cpu_hold !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL drain_hold got %b/%b exp 1/0", cpu_hold, gnt0); end
    checks++; if (mem_addr !== 32'h0 || mem_re !== 1'b0) begin errors++; $display("FAIL drain_idle got %h/%b exp 0/0", mem_addr, mem_re); end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL run_hold got %b exp 0", cpu_hold); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 0; addr0 = 32'h20;
    @(negedge clk);
    checks++; if ({gnt0, mem_re, rvalid0} !== 3'b110) begin errors++; $display("FAIL b2b_c1 got %b exp 110", {gnt0, mem_re, rvalid0}); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL b2b_addr1 got %h exp 00000020", mem_addr); end
    next_cycle();
    addr0 = 32'h24;
    @(negedge clk);
    checks++; if ({gnt0, rvalid0, rvalid1} !== 3'b110) begin errors++; $display("FAIL b2b_c2 got %b exp 110", {gnt0, rvalid0, rvalid1}); end
    checks++; if (rdata0 !== 32'h11112222) begin errors++; $display("FAIL b2b_data1 got %h exp 11112222", rdata0); end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    checks++; if ({gnt0, rvalid0, rvalid1} !== 3'b010) begin errors++; $display("FAIL b2b_c3 got %b exp 010", {gnt0, rvalid0, rvalid1}); end
    checks++; if (rdata0 !== 32'h33334444) begin errors++; $display("FAIL b2b_data2 got %h exp 33334444", rdata0); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL b2b_c4 got %b exp 00", {rvalid0, rvalid1}); end
    next_cycle();
  endtask

  task automatic test_boot_done_in_run();
    boot_done = 1;
    req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'h55;
    @(negedge clk);
    checks++; if ({gnt1, cpu_hold} !== 2'b10) begin errors++; $display("FAIL bdrun_c1 got %b exp 10", {gnt1, cpu_hold}); end
    next_cycle();
    clear_inputs();
    req0 = 1; we0 = 1; addr0 = 32'h34; wdata0 = 32'h66;
    @(negedge clk);
    checks++; if ({gnt0, cpu_hold} !== 2'b10) begin errors++; $display("FAIL bdrun_c2 got %b exp 10", {gnt0, cpu_hold}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; we0 = 0; addr0 = 32'h20;
    @(negedge clk);
    checks++; if ({gnt0, mem_re} !== 2'b11) begin errors++; $display("FAIL rmr_grant got %b exp 11", {gnt0, mem_re}); end
    next_cycle();
    req0 = 0; reset = 1;
    @(negedge clk);
    checks++; if ({rvalid0, cpu_hold} !== 2'b01) begin errors++; $display("FAIL rmr_rst got %b exp 01", {rvalid0, cpu_hold}); end
    next_cycle();
    reset = 0; req0 = 1;
    @(negedge clk);
    checks++; if ({gnt0, cpu_hold, rvalid0} !== 3'b010) begin errors++; $display("FAIL rmr_boot got %b exp 010", {gnt0, cpu_hold, rvalid0}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_tie();
    logic [1:0] exp_seq [0:3];
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
    boot_done = 1;
    next_cycle();
    boot_done = 0;
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL tie_drain got %b exp 1", cpu_hold); end
    next_cycle();
    req0 = 1; we0 = 1; addr0 = 32'h38; wdata0 = 32'hA;
    req1 = 1; we1 = 1; addr1 = 32'h3C; wdata1 = 32'hB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt1, gnt0} !== exp_seq[i]) begin
        errors++; $display("FAIL tie_cycle%0d got %b exp %b", i, {gnt1, gnt0}, exp_seq[i]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_boot_write();
    test_boot_read_done();
    test_back_to_back();
    test_boot_done_in_run();
    test_reset_mid_read();
    test_tie();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
